dm_dump_tx: RTL and testbench

Read-out engine for the MIPS data memory: on a start pulse it reads a run of words from the data memory port and streams each one as 8 uppercase ASCII hex characters plus a newline over a UART 8N1 serial line. It is the hardware counterpart of the testbench's `$readmemh` loading: it reads final memory state back out on a pin, so board runs and simulation can be compared against the same golden `data.txt` format. It sits beside `M_dm` on a second read port and drives the board's `txd` pin.

---
 rtl/dump_pkg.sv | 26 ++
 rtl/dm_dump_tx_uart_tx.sv | 116 +++++++++++
 rtl/dm_dump_tx.sv | 143 ++++++++++++++
 tb/tb_dm_dump_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
// Shared types and helpers for the data-memory dump engine.
package dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_FIN     = 3'd4
  } dump_state_e;

  localparam logic [7:0] ASCII_NL       = 8'h0A;
  localparam logic [3:0] CHARS_PER_WORD = 4'd9;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    logic [7:0] chr;
    if (nib < 4'd10) begin
      chr = 8'h30 + {4'h0, nib};
    end else begin
      chr = 8'h37 + {4'h0, nib};
    end
    return chr;
  endfunction

endpackage

// File: rtl/dm_dump_tx_uart_tx.sv
// 8N1 serial transmitter; ready in idle and in the last stop-bit cycle so
// consecutive bytes stream with no idle bit between frames.
module uart_tx #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd
);

  localparam int            CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_state_e;

  uart_state_e   state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    sh_r, sh_s;
  logic          txd_r, txd_s;
  logic          bit_end_s, ready_s, accept_s;

  assign bit_end_s = (cnt_r == CNT_LAST);

  // state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= U_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      U_IDLE: begin
        if (tx_valid) state_s = U_START;
        else          state_s = U_IDLE;
      end
      U_START: begin
        if (bit_end_s) state_s = U_DATA;
        else           state_s = U_START;
      end
      U_DATA: begin
        if (bit_end_s && (bit_r == 3'd7)) state_s = U_STOP;
        else                              state_s = U_DATA;
      end
      U_STOP: begin
        if (bit_end_s) begin
          if (tx_valid) state_s = U_START;
          else          state_s = U_IDLE;
        end else begin
          state_s = U_STOP;
        end
      end
      default: state_s = U_IDLE;
    endcase
  end

  // handshake, next datapath values and next line level
  always_comb begin
    ready_s  = (state_r == U_IDLE) || ((state_r == U_STOP) && bit_end_s);
    accept_s = tx_valid && ready_s;
    if (accept_s || (state_r == U_IDLE) || bit_end_s) begin
      cnt_s = CNT_ZERO;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
    if (accept_s) begin
      sh_s  = tx_data;
      bit_s = 3'd0;
    end else if ((state_r == U_DATA) && bit_end_s) begin
      sh_s  = {1'b0, sh_r[7:1]};
      bit_s = bit_r + 3'd1;
    end else begin
      sh_s  = sh_r;
      bit_s = bit_r;
    end
    case (state_s)
      U_START: txd_s = 1'b0;
      U_DATA:  txd_s = sh_s[0];
      default: txd_s = 1'b1;
    endcase
  end

  // datapath and registered line output
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= CNT_ZERO;
      bit_r <= 3'd0;
      sh_r  <= 8'h00;
      txd_r <= 1'b1;
    end else begin
      cnt_r <= cnt_s;
      bit_r <= bit_s;
      sh_r  <= sh_s;
      txd_r <= txd_s;
    end
  end

  assign tx_ready = ready_s;
  assign txd      = txd_r;

endmodule

// File: rtl/dm_dump_tx.sv
// Streams a run of data-memory words out of txd as uppercase hex lines,
// matching the data.txt format used to preload memory in simulation.
module dm_dump_tx
  import dump_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int CLK_DIV = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              txd
);

  localparam logic [ADDR_W:0]   IDX_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  dump_state_e       state_r, state_s;
  logic [ADDR_W:0]   count_r, idx_r;
  logic [31:0]       word_r, word_sh_s;
  logic [3:0]        char_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              busy_r, done_r, rdy_q_r;
  logic              tx_valid_s, tx_ready_s, accept_s;
  logic              last_char_s, last_word_s, finish_s;
  logic [7:0]        tx_data_s;

  assign accept_s    = tx_valid_s && tx_ready_s;
  assign last_char_s = (char_r == (CHARS_PER_WORD - 4'd1));
  assign last_word_s = ((idx_r + IDX_ONE) == count_r);
  // The transmitter is idle only once ready has held for two cycles; the
  // last stop-bit cycle alone is not enough. busy_r gates the count=0 path.
  assign finish_s    = (state_r == ST_FIN) && tx_ready_s && rdy_q_r && busy_r;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (count == IDX_ZERO) state_s = ST_FIN;
          else                   state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH:   state_s = ST_CAPTURE;
      ST_CAPTURE: state_s = ST_SEND;
      ST_SEND: begin
        if (accept_s && last_char_s) begin
          if (last_word_s) state_s = ST_FIN;
          else             state_s = ST_FETCH;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_FIN: begin
        if (finish_s) state_s = ST_IDLE;
        else          state_s = ST_FIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // character offered to the transmitter
  always_comb begin
    tx_valid_s = (state_r == ST_SEND);
    word_sh_s  = word_r << {char_r[2:0], 2'b00};
    if (last_char_s) begin
      tx_data_s = ASCII_NL;
    end else begin
      tx_data_s = hex2ascii(word_sh_s[31:28]);
    end
  end

  // word index, buffers and status registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r    <= IDX_ZERO;
      idx_r      <= IDX_ZERO;
      word_r     <= 32'h0000_0000;
      char_r     <= 4'd0;
      mem_addr_r <= ADDR_ZERO;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rdy_q_r    <= 1'b0;
    end else begin
      rdy_q_r <= tx_ready_s;
      done_r  <= finish_s;
      busy_r  <= (state_r != ST_IDLE) && !finish_s;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            count_r <= count;
            idx_r   <= IDX_ZERO;
          end
        end
        ST_FETCH: mem_addr_r <= idx_r[ADDR_W-1:0];
        ST_CAPTURE: begin
          word_r <= mem_rdata;
          char_r <= 4'd0;
        end
        ST_SEND: begin
          if (accept_s) begin
            char_r <= char_r + 4'd1;
            if (last_char_s) idx_r <= idx_r + IDX_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  uart_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (tx_valid_s),
    .tx_data  (tx_data_s),
    .tx_ready (tx_ready_s),
    .txd      (txd)
  );

  assign mem_addr = mem_addr_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_dm_dump_tx.sv
// Bench for dm_dump_tx: a bit-level txd decoder plus an expected-text model
// built from the memory image and the line-timing formula.
module tb_dm_dump_tx;

  localparam int AW = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   count;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          busy, done, txd;

  logic [31:0] mem [16];
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  rxq[$];
  int          fstart[$];
  int          frame_err = 0;

  dm_dump_tx #(.ADDR_W(AW), .CLK_DIV(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .txd       (txd)
  );

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // txd decoder: checks each bit is held D cycles and framing is 8N1
  initial begin
    logic [9:0] bits;
    int         st;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        st = cyc;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < D; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) bits[b] = txd;
            else if (txd !== bits[b]) frame_err++;
          end
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_err++;
        rxq.push_back(bits[8:1]);
        fstart.push_back(st);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] hexch(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + 8'(v);
    else return 8'h41 + 8'(v) - 8'd10;
  endfunction

  task automatic do_dump(input int n, input int poke_off, input int poke_cnt);
    logic [7:0] expq[$];
    int base, ebase, t0, tdone, busy_cyc, ndone, amax, got, nbad, ngap, bi, k, exp_done;
    logic [7:0] bo, be;
    for (int w = 0; w < n; w++) begin
      for (int c = 0; c < 8; c++) expq.push_back(hexch(4'((mem[w] >> (28 - 4 * c)) & 32'hF)));
      expq.push_back(8'h0A);
    end
    exp_done = (n == 0) ? 2 : 4 + 90 * D * n;
    base = rxq.size();
    ebase = frame_err;
    @(negedge clk); start = 1'b1; count = (AW+1)'(n);
    @(negedge clk); start = 1'b0; t0 = cyc;
    chk("busy_at_start_edge", busy, 0);
    @(negedge clk);
    chk("busy_edge1", busy, 1);
    if (n > 0) chk("mem_addr_edge1", mem_addr, 0);
    tdone = -1; busy_cyc = 0; amax = 0; k = 0;
    while (tdone < 0 && k < exp_done + 20) begin
      if (poke_off > 0 && cyc - t0 == poke_off) begin
        start = 1'b1; count = (AW+1)'(poke_cnt);
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cyc++;
      if (int'(mem_addr) > amax) amax = int'(mem_addr);
      if (done) tdone = cyc - t0;
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    ndone = (tdone >= 0) ? 1 : 0;
    repeat (30) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("done_time", tdone, exp_done);
    chk("done_once", ndone, 1);
    chk("busy_cycles", busy_cyc, exp_done - 1);
    got = rxq.size() - base;
    chk("byte_count", got, 9 * n);
    nbad = 0; ngap = 0; bi = 0; bo = 8'h00; be = 8'h00;
    for (int i = 0; i < got && i < 9 * n; i++) begin
      if (rxq[base + i] !== expq[i]) begin
        if (nbad == 0) begin bi = i; bo = rxq[base + i]; be = expq[i]; end
        nbad++;
      end
      if (i > 0 && fstart[base + i] - fstart[base + i - 1] != 10 * D) ngap++;
    end
    chk($sformatf("payload_bad_bytes(first idx %0d got %h want %h)", bi, bo, be), nbad, 0);
    chk("byte_gaps", ngap, 0);
    chk("frame_errors", frame_err - ebase, 0);
    if (got > 0) chk("first_start_bit_cycle", fstart[base] - t0, 3);
    if (n > 0) begin
      chk("mem_addr_max", amax, n - 1);
      chk("mem_addr_final", mem_addr, n - 1);
    end
  endtask

  task automatic reset_mid(input int byte_no, input int n);
    int base, t0, target, nd, low;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    base = rxq.size();
    @(negedge clk); start = 1'b1; count = (AW+1)'(n);
    @(negedge clk); start = 1'b0; t0 = cyc;
    target = t0 + 3 + byte_no * 10 * D + D + 2;
    while (cyc < target) @(negedge clk);
    chk("bytes_before_reset", rxq.size() - base, byte_no);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    nd = 0; low = 0;
    repeat (14 * D) begin
      @(negedge clk);
      if (done) nd++;
      if (txd !== 1'b1) low++;
    end
    chk("no_done_after_reset", nd, 0);
    chk("txd_low_after_reset", low, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; count = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_mem_addr", mem_addr, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    mem[0] = 32'h1234_5678;
    do_dump(1, 0, 0);

    mem[0] = 32'hDEAD_BEEF; mem[1] = 32'h0000_000A;
    do_dump(2, 0, 0);

    do_dump(0, 0, 0);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      do_dump(int'($urandom_range(1, 4)), 0, 0);
    end

    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    do_dump(2, 100, 5);

    reset_mid(2, 3);
    do_dump(2, 0, 0);
    reset_mid(11, 3);

    for (int i = 0; i < 16; i++) mem[i] = i;
    do_dump(16, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
